// File: rtl/cond_unit_if.sv
// cond_unit_if: bundle of decoder/ALU inputs and gated strobes around the condition unit
//  master : drives valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write;
//           observes cond_ex, pc_src, reg_write, mem_write, flags, squash_count
//  slave  : the condition unit itself (opposite directions)
interface cond_unit_if #(parameter int CNT_W = 16);
  logic             valid;
  logic             stall;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_w;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             no_write;
  logic             cond_ex;
  logic             pc_src;
  logic             reg_write;
  logic             mem_write;
  logic [3:0]       flags;
  logic [CNT_W-1:0] squash_count;
  modport master (
    output valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
    input  cond_ex, pc_src, reg_write, mem_write, flags, squash_count
  );
  modport slave (
    input  valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
    output cond_ex, pc_src, reg_write, mem_write, flags, squash_count
  );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: ARM flags register, condition evaluation and write-strobe gating
//  clk, reset_n (async active-low) plain ports; everything else on bus (cond_unit_if.slave)
//  COND_UNIT_SQUASH_CNT_EN defined: saturating squashed-instruction counter on squash_count
//  otherwise squash_count is tied to 0
module cond_unit #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        reset_n,
  cond_unit_if.slave bus
);
  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v, fire, upd;
  logic [15:0] tbl;
  always_comb begin
    {n, z, c, v} = flags_q;
    // indexed by cond: bit k is the pass condition for code k (AL and 0xF always pass)
    tbl = {1'b1, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
           ~v, v, ~n, n, ~c, c, ~z, z};
    bus.cond_ex = tbl[bus.cond];
    fire = bus.valid & ~bus.stall;
    upd = fire & bus.cond_ex;
    bus.pc_src = upd & bus.pcs;
    bus.reg_write = upd & bus.reg_w & ~bus.no_write;
    bus.mem_write = upd & bus.mem_w;
    flags_d[3:2] = (upd & bus.flag_w[1]) ? bus.alu_flags[3:2] : flags_q[3:2];
    flags_d[1:0] = (upd & bus.flag_w[0]) ? bus.alu_flags[1:0] : flags_q[1:0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) flags_q <= 4'b0000;
    else flags_q <= flags_d;
  assign bus.flags = flags_q;
`ifdef COND_UNIT_SQUASH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (fire & ~bus.cond_ex & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.squash_count = cnt_q;
`else
  assign bus.squash_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: table-driven check of condition evaluation, strobe gating, flag writes and squash counter
module tb_cond_unit;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  int sq = 0;
  cond_unit_if #(.CNT_W(CW)) bus ();
  cond_unit #(.CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial begin
    #20;
    forever #5 clk = ~clk;
  end
  typedef struct {
    logic [3:0] pre;
    logic [3:0] cond;
    logic       valid;
    logic       stall;
    logic [1:0] fw;
    logic [3:0] alu;
    logic       pcs, reg_w, mem_w, no_write;
    logic       e_ce, e_pc, e_rw, e_mw;
    logic [3:0] e_flags;
  } vec_t;
  vec_t vt[24];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic vld, input logic stl, input logic [3:0] cnd, input logic [1:0] fw,
                       input logic [3:0] alu, input logic p, input logic r, input logic m, input logic nw);
    bus.valid = vld; bus.stall = stl; bus.cond = cnd; bus.flag_w = fw; bus.alu_flags = alu;
    bus.pcs = p; bus.reg_w = r; bus.mem_w = m; bus.no_write = nw;
  endtask
  task automatic load_flags(input logic [3:0] f);
    drive(1, 0, 4'hE, 2'b11, f, 0, 0, 0, 0);
    tick();
  endtask
  function automatic logic [31:0] sq_exp();
`ifdef COND_UNIT_SQUASH_CNT_EN
    return sq;
`else
    return 0;
`endif
  endfunction
  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? x : x + 1;
  endfunction
  initial begin
    //        pre     cond  v  s  fw     alu    p  r  m  nw  ce pc rw mw flags
    vt[0]  = '{4'b0100, 4'h0, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0100};
    vt[1]  = '{4'b0000, 4'h0, 1, 0, 2'b11, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0000};
    vt[2]  = '{4'b1111, 4'h2, 1, 0, 2'b10, 4'h0, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0011};
    vt[3]  = '{4'b0000, 4'h3, 1, 0, 2'b01, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0011};
    vt[4]  = '{4'b1000, 4'h4, 1, 0, 2'b00, 4'hF, 1, 1, 1, 1, 1, 1, 0, 1, 4'b1000};
    vt[5]  = '{4'b1000, 4'h5, 1, 0, 2'b11, 4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 4'b1000};
    vt[6]  = '{4'b0001, 4'h6, 1, 0, 2'b00, 4'hF, 0, 1, 0, 0, 1, 0, 1, 0, 4'b0001};
    vt[7]  = '{4'b0001, 4'h7, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0001};
    vt[8]  = '{4'b0010, 4'h8, 1, 0, 2'b00, 4'hF, 1, 0, 1, 0, 1, 1, 0, 1, 4'b0010};
    vt[9]  = '{4'b0110, 4'h8, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0110};
    vt[10] = '{4'b0110, 4'h9, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0110};
    vt[11] = '{4'b1001, 4'hA, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b1001};
    vt[12] = '{4'b1000, 4'hA, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b1000};
    vt[13] = '{4'b1000, 4'hB, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b1000};
    vt[14] = '{4'b0000, 4'hC, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0000};
    vt[15] = '{4'b0100, 4'hC, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0100};
    vt[16] = '{4'b0100, 4'hD, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0100};
    vt[17] = '{4'b0001, 4'hD, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0001};
    vt[18] = '{4'b0000, 4'hD, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0000};
    vt[19] = '{4'b0000, 4'hE, 1, 0, 2'b11, 4'hA, 1, 1, 1, 0, 1, 1, 1, 1, 4'b1010};
    vt[20] = '{4'b0100, 4'hF, 1, 0, 2'b00, 4'hF, 1, 1, 1, 0, 1, 1, 1, 1, 4'b0100};
    vt[21] = '{4'b0000, 4'hE, 1, 1, 2'b11, 4'hF, 1, 1, 1, 0, 1, 0, 0, 0, 4'b0000};
    vt[22] = '{4'b0000, 4'h0, 0, 0, 2'b11, 4'hF, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0000};
    vt[23] = '{4'b0000, 4'hE, 0, 0, 2'b11, 4'hF, 1, 1, 1, 0, 1, 0, 0, 0, 4'b0000};
    reset_n = 1'b0;
    drive(0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
    #2;
    chk("reset_flags", bus.flags, 0);
    chk("reset_squash", bus.squash_count, 0);
    chk("reset_eq", bus.cond_ex, 0);
    bus.cond = 4'h1;
    #1;
    chk("reset_ne", bus.cond_ex, 1);
    #20;
    reset_n = 1'b1;
    tick();
    // flags must come from the register, not from alu_flags in the same cycle
    drive(1, 0, 4'h0, 2'b11, 4'b0100, 1, 0, 0, 0);
    #1;
    chk("cmp_same_cycle_eq", bus.cond_ex, 0);
    bus.cond = 4'hE;
    #1;
    chk("cmp_al_pc", bus.pc_src, 1);
    tick();
    chk("cmp_flags", bus.flags, 4'b0100);
    drive(1, 0, 4'h0, 2'b00, 4'h0, 1, 0, 0, 0);
    #1;
    chk("branch_cond_ex", bus.cond_ex, 1);
    chk("branch_pc_src", bus.pc_src, 1);
    tick();
    for (int i = 0; i < 24; i++) begin
      load_flags(vt[i].pre);
      drive(vt[i].valid, vt[i].stall, vt[i].cond, vt[i].fw, vt[i].alu,
            vt[i].pcs, vt[i].reg_w, vt[i].mem_w, vt[i].no_write);
      #1;
      chk($sformatf("v%0d_cond_ex", i), bus.cond_ex, vt[i].e_ce);
      chk($sformatf("v%0d_pc_src", i), bus.pc_src, vt[i].e_pc);
      chk($sformatf("v%0d_reg_write", i), bus.reg_write, vt[i].e_rw);
      chk($sformatf("v%0d_mem_write", i), bus.mem_write, vt[i].e_mw);
      if (vt[i].valid && !vt[i].stall && !vt[i].e_ce) sq = sat(sq);
      tick();
      chk($sformatf("v%0d_flags", i), bus.flags, vt[i].e_flags);
      chk($sformatf("v%0d_squash", i), bus.squash_count, sq_exp());
    end
    // saturation and asynchronous reset mid-sequence
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    sq = 0;
    chk("sat_reset", bus.squash_count, 0);
    tick();
    load_flags(4'b1010);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4'h6, 2'b11, 4'hF, 0, 1, 1, 0);
      #1;
      chk($sformatf("sat%0d_cond_ex", i), bus.cond_ex, 0);
      sq = sat(sq);
      tick();
      chk($sformatf("sat%0d_squash", i), bus.squash_count, sq_exp());
      chk($sformatf("sat%0d_flags", i), bus.flags, 4'b1010);
    end
`ifdef COND_UNIT_SQUASH_CNT_EN
    chk("sat_final", bus.squash_count, 3);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_squash", bus.squash_count, 0);
    chk("midreset_flags", bus.flags, 0);
    reset_n = 1'b1;
    sq = 0;
    @(negedge clk);
    drive(1, 0, 4'h6, 2'b00, 4'h0, 0, 0, 0, 0);
    sq = sat(sq);
    tick();
    chk("resume_squash", bus.squash_count, sq_exp());
    chk("resume_flags", bus.flags, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end
endmodule
